ram_io_responder: RTL and testbench

Memory-side responder on the CPU's byte-wide memory bus. It answers the CPU memory controller's reads and writes. It holds the 128 KB byte RAM, and maps the I/O window at 0x30000 onto a UART-facing receive FIFO and transmit FIFO, a free-running cycle counter and the program-stop flag. It sits outside `cpu`, wired to `mem_a`, `mem_dout`, `mem_wr` and `mem_din`.

---
 rtl/ram_io_responder_pkg.sv | 32 +++
 rtl/ram_io_responder_byte_fifo.sv | 54 +++++
 rtl/ram_io_responder.sv | 151 +++++++++++++++
 tb/tb_ram_io_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_io_responder_pkg.sv
// rtl/ram_io_responder_pkg.sv - shared bus types, I/O map and address decode for ram_io_responder
//
// Purpose: common definitions for the memory-side responder: bus widths,
// the I/O window base and port offsets, and the region decode helper.
// Ports: none (package).

package ram_io_responder_pkg;

  typedef logic [7:0]  mem_bus_t;
  typedef logic [31:0] mem_addr_bus_t;

  localparam logic [17:0] IO_BASE      = 18'h30000;
  localparam logic [15:0] IO_PORT_DATA = 16'h0000;
  localparam logic [15:0] IO_PORT_CLK  = 16'h0004;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_IO,
    REGION_UNMAPPED
  } region_e;

  // Only the low 18 address bits take part in the decode.
  function automatic region_e decode_region(input logic [17:0] addr);
    if (!addr[17])
      return REGION_RAM;
    else if (addr[17:16] == IO_BASE[17:16])
      return REGION_IO;
    else
      return REGION_UNMAPPED;
  endfunction

endpackage

// File: rtl/ram_io_responder_byte_fifo.sv
// rtl/ram_io_responder_byte_fifo.sv - byte-wide synchronous FIFO used for the RX and TX queues
//
// Purpose: 2**FIFO_AW-entry byte FIFO with first-word-fall-through output.
// Ports:
//   clk_in, rst_in   clock, synchronous active-high reset (empties the FIFO)
//   push, din        write request and data
//   pop              read request; dout shows the head combinationally
//   full, empty      occupancy flags

module byte_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  logic [7:0]       mem [2**FIFO_AW];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // still lands when it is paired with a pop.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign dout = mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr[FIFO_AW-1:0]] <= din;
  end

endmodule

// File: rtl/ram_io_responder.sv
// rtl/ram_io_responder.sv - CPU byte-bus responder: RAM, RX/TX FIFOs, cycle counter, stop flag
//
// Purpose: answers CPU reads/writes on the byte-wide memory bus. Low half of
// the 18-bit space is RAM, 0x30000.. is the I/O window, 0x20000.. is unmapped.
// Ports:
//   clk_in, rst_in           clock, synchronous active-high reset
//   cpu_rdy                  access in this cycle is honoured only when high
//   mem_a, mem_dout, mem_wr  CPU address, write data, write strobe
//   mem_din                  registered read data (one-cycle latency)
//   rx_data/valid/ready      UART receive side, feeds the RX FIFO
//   tx_data/valid/ready      UART transmit side, drained from the TX FIFO
//   program_stop             sticky, set by a write to 0x30004
//   tx_overflow              sticky, a TX byte was dropped on a full FIFO

module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int RAM_AW    = 17,
  parameter int FIFO_AW   = 4,
  parameter     INIT_FILE = ""
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          cpu_rdy,
  input  mem_addr_bus_t mem_a,
  input  mem_bus_t      mem_dout,
  input  logic          mem_wr,
  output mem_bus_t      mem_din,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          program_stop,
  output logic          tx_overflow
);

  logic [7:0]  ram [2**RAM_AW];
  logic [31:0] cycle_cnt;
  logic [31:0] cnt_snap;

  region_e     region;
  logic [15:0] io_off;
  logic        wr_ok;
  logic        rd_ok;
  logic        ram_we;
  logic        tx_push_req;
  logic [7:0]  tx_push_data;
  logic        tx_pop;
  logic        tx_full;
  logic        tx_empty;
  logic        rx_pop;
  logic        rx_full;
  logic        rx_empty;
  logic [7:0]  rx_head;
  logic        snap_we;
  logic [7:0]  rd_data;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^mem_a[31:18];

  assign region = decode_region(mem_a[17:0]);
  assign io_off = mem_a[15:0];

  // Once stopped, every CPU write is discarded; reads keep being served.
  assign wr_ok  = cpu_rdy && mem_wr && !program_stop;
  assign rd_ok  = cpu_rdy && !mem_wr;
  assign ram_we = wr_ok && (region == REGION_RAM);

  // The stop write queues a 0x00 terminator, which the data port would ignore.
  always_comb begin
    tx_push_req  = 1'b0;
    tx_push_data = mem_dout;
    if (wr_ok && region == REGION_IO) begin
      if (io_off == IO_PORT_DATA) begin
        tx_push_req = (mem_dout != 8'h00);
      end else if (io_off == IO_PORT_CLK) begin
        tx_push_req  = 1'b1;
        tx_push_data = 8'h00;
      end
    end
  end

  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_ready = !rx_full;
  assign rx_pop   = rd_ok && (region == REGION_IO) && (io_off == IO_PORT_DATA);
  assign snap_we  = rd_ok && (region == REGION_IO) && (io_off == IO_PORT_CLK);

  always_comb begin
    rd_data = 8'h00;
    case (region)
      REGION_RAM: rd_data = ram[mem_a[RAM_AW-1:0]];
      REGION_IO: begin
        case (io_off)
          IO_PORT_DATA:        rd_data = rx_empty ? 8'h00 : rx_head;
          IO_PORT_CLK:         rd_data = cycle_cnt[7:0];
          IO_PORT_CLK + 16'd1: rd_data = cnt_snap[15:8];
          IO_PORT_CLK + 16'd2: rd_data = cnt_snap[23:16];
          IO_PORT_CLK + 16'd3: rd_data = cnt_snap[31:24];
          default:             rd_data = 8'h00;
        endcase
      end
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[mem_a[RAM_AW-1:0]] <= mem_dout;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_din      <= 8'h00;
      cycle_cnt    <= 32'd0;
      cnt_snap     <= 32'd0;
      program_stop <= 1'b0;
      tx_overflow  <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (rd_ok) mem_din <= rd_data;
      if (snap_we) cnt_snap <= cycle_cnt;
      if (wr_ok && region == REGION_IO && io_off == IO_PORT_CLK) program_stop <= 1'b1;
      if (tx_push_req && tx_full && !tx_pop) tx_overflow <= 1'b1;
    end
  end

  byte_fifo #(.FIFO_AW(FIFO_AW)) u_rx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (rx_valid && rx_ready),
    .pop    (rx_pop),
    .din    (rx_data),
    .dout   (rx_head),
    .full   (rx_full),
    .empty  (rx_empty)
  );

  byte_fifo #(.FIFO_AW(FIFO_AW)) u_tx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (tx_push_req),
    .pop    (tx_pop),
    .din    (tx_push_data),
    .dout   (tx_data),
    .full   (tx_full),
    .empty  (tx_empty)
  );

endmodule

// File: tb/tb_ram_io_responder.sv
// tb/tb_ram_io_responder.sv - directed table-driven bench for ram_io_responder

module tb_ram_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        cpu_rdy;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        program_stop;
  logic        tx_overflow;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  ram_io_responder dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .cpu_rdy      (cpu_rdy),
    .mem_a        (mem_a),
    .mem_dout     (mem_dout),
    .mem_wr       (mem_wr),
    .mem_din      (mem_din),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .program_stop (program_stop),
    .tx_overflow  (tx_overflow)
  );

  typedef struct {
    logic        rdy;
    logic [31:0] a;
    logic        wr;
    logic [7:0]  d;
    logic        rxv;
    logic [7:0]  rxd;
    logic        chk_din;
    logic [7:0]  din;
    logic        txv;
    logic        rxr;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus(input logic rdy, input logic [31:0] a, input logic wr, input logic [7:0] d);
    cpu_rdy  = rdy;
    mem_a    = a;
    mem_wr   = wr;
    mem_dout = d;
  endtask

  logic [7:0] exp_tx [$];

  initial begin
    //                 rdy  addr          wr  data   rxv  rxd    chk din    txv rxr
    vt[0]  = '{1'b1, 32'h00011, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    vt[1]  = '{1'b1, 32'h00010, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    vt[2]  = '{1'b1, 32'h00010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b1};
    vt[3]  = '{1'b1, 32'h00011, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b1};
    vt[4]  = '{1'b1, 32'h20000, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    vt[5]  = '{1'b1, 32'h20000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1};
    vt[6]  = '{1'b1, 32'h00020, 1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    vt[7]  = '{1'b1, 32'h20000, 1'b0, 8'h00, 1'b1, 8'h41, 1'b1, 8'h00, 1'b0, 1'b1};
    vt[8]  = '{1'b1, 32'h20000, 1'b0, 8'h00, 1'b1, 8'h42, 1'b1, 8'h00, 1'b0, 1'b1};
    vt[9]  = '{1'b1, 32'h30000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 1'b1};
    vt[10] = '{1'b1, 32'h30000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h42, 1'b0, 1'b1};
    vt[11] = '{1'b1, 32'h30000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1};
    vt[12] = '{1'b1, 32'h30000, 1'b1, 8'h48, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[13] = '{1'b1, 32'h30000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[14] = '{1'b1, 32'h30000, 1'b1, 8'h49, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[15] = '{1'b1, 32'h30003, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1};

    rst_in   = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    bus(1'b0, 32'h0, 1'b0, 8'h00);
    cyc();
    cyc();
    rst_in = 1'b0;

    // Reset state, sampled in post-reset cycle 0.
    chk("reset_mem_din", mem_din, 8'h00);
    chk("reset_tx_valid", tx_valid, 1'b0);
    chk("reset_rx_ready", rx_ready, 1'b1);
    chk("reset_program_stop", program_stop, 1'b0);
    chk("reset_tx_overflow", tx_overflow, 1'b0);

    // Cycle counter: the 0x30004 read is presented in post-reset cycle 0x1FF.
    repeat (32'h1FF) cyc();
    bus(1'b1, 32'h30004, 1'b0, 8'h00); cyc(); chk("cnt_byte0", mem_din, 8'hFF);
    bus(1'b1, 32'h30005, 1'b0, 8'h00); cyc(); chk("cnt_byte1", mem_din, 8'h01);
    bus(1'b1, 32'h30006, 1'b0, 8'h00); cyc(); chk("cnt_byte2", mem_din, 8'h00);
    bus(1'b1, 32'h30007, 1'b0, 8'h00); cyc(); chk("cnt_byte3", mem_din, 8'h00);
    bus(1'b0, 32'h0, 1'b0, 8'h00);
    repeat (256) cyc();
    bus(1'b1, 32'h30005, 1'b0, 8'h00); cyc(); chk("cnt_snap_stable", mem_din, 8'h01);

    // Table: RAM, unmapped region, RX pops, TX pushes with zero-ignore.
    for (int i = 0; i < 16; i++) begin
      bus(vt[i].rdy, vt[i].a, vt[i].wr, vt[i].d);
      rx_valid = vt[i].rxv;
      rx_data  = vt[i].rxd;
      cyc();
      if (vt[i].chk_din) chk($sformatf("vec%0d_mem_din", i), mem_din, vt[i].din);
      chk($sformatf("vec%0d_tx_valid", i), tx_valid, vt[i].txv);
      chk($sformatf("vec%0d_rx_ready", i), rx_ready, vt[i].rxr);
    end
    rx_valid = 1'b0;
    exp_tx.push_back(8'h48);
    exp_tx.push_back(8'h49);

    // TX fill: 14 more bytes reach 16 entries, the next 3 overflow.
    for (int i = 0; i < 17; i++) begin
      bus(1'b1, 32'h30000, 1'b1, 8'h50 + 8'(i));
      cyc();
      if (i < 14) exp_tx.push_back(8'h50 + 8'(i));
      if (i == 13) chk("tx_no_overflow_at_16", tx_overflow, 1'b0);
    end
    chk("tx_overflow_set", tx_overflow, 1'b1);
    chk("tx_head_kept", tx_data, 8'h48);

    bus(1'b0, 32'h0, 1'b0, 8'h00);
    tx_ready = 1'b1;
    foreach (exp_tx[k]) begin
      chk($sformatf("tx_valid_%0d", k), tx_valid, 1'b1);
      chk($sformatf("tx_data_%0d", k), tx_data, exp_tx[k]);
      cyc();
    end
    chk("tx_drained", tx_valid, 1'b0);
    tx_ready = 1'b0;

    // Program stop: 0x00 queued, later RAM and TX writes ignored.
    bus(1'b1, 32'h30004, 1'b1, 8'h99); cyc();
    chk("stop_set", program_stop, 1'b1);
    chk("stop_tx_valid", tx_valid, 1'b1);
    chk("stop_tx_zero", tx_data, 8'h00);
    bus(1'b1, 32'h00020, 1'b1, 8'h99); cyc();
    bus(1'b1, 32'h30000, 1'b1, 8'h61); cyc();
    bus(1'b1, 32'h00020, 1'b0, 8'h00); cyc();
    chk("stop_ram_unchanged", mem_din, 8'h33);
    bus(1'b0, 32'h0, 1'b0, 8'h00);
    tx_ready = 1'b1;
    cyc();
    chk("stop_only_one_tx", tx_valid, 1'b0);
    tx_ready = 1'b0;

    // cpu_rdy low: a held 0x30000 read neither pops nor updates mem_din.
    rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data = 8'hC1 + 8'(i);
      cyc();
    end
    rx_valid = 1'b0;
    bus(1'b0, 32'h30000, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("rdy_low_hold_%0d", i), mem_din, 8'h33);
    end
    bus(1'b1, 32'h30000, 1'b0, 8'h00); cyc();
    chk("rdy_high_pop_first", mem_din, 8'hC1);

    // Reset mid-stream: FIFOs flushed, flags and mem_din cleared.
    rst_in = 1'b1;
    cyc();
    rst_in = 1'b0;
    chk("rst_mid_mem_din", mem_din, 8'h00);
    chk("rst_mid_rx_ready", rx_ready, 1'b1);
    chk("rst_mid_tx_valid", tx_valid, 1'b0);
    chk("rst_mid_stop", program_stop, 1'b0);
    chk("rst_mid_overflow", tx_overflow, 1'b0);
    bus(1'b1, 32'h20000, 1'b0, 8'h00); cyc();
    bus(1'b1, 32'h30000, 1'b0, 8'h00); cyc();
    chk("rst_mid_rx_empty", mem_din, 8'h00);
    bus(1'b1, 32'h30000, 1'b1, 8'h70); cyc();
    chk("post_rst_tx_push", tx_valid, 1'b1);
    chk("post_rst_tx_data", tx_data, 8'h70);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
